spi_target_byte: RTL and testbench

- True SPI slave (target) endpoint: responds to an external SPI master and never drives SCLK or CS.
- Oversamples CS/SCLK/MOSI on sys_clk and shifts out MISO.
- Presents received bytes to fabric with a one-cycle valid pulse; takes transmit bytes through a valid/ready handshake.
- Sits between the MCU SPI pins and the register/command layer of the FPGA.

---
 rtl/spi_target_byte.sv | 151 +++++++++++++++
 tb/tb_spi_target_byte.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_byte.sv
// SPI target endpoint: oversamples CS/SCLK/MOSI on the system clock, shifts MISO out,
// and exchanges whole bytes with the fabric (rx pulse, tx valid/ready).
//
// state  | meaning
// IDLE   | not selected: MISO released, SCLK edges ignored
// ACTIVE | selected: sampling MOSI and shifting MISO on the configured edges
module spi_target_byte #(
  parameter logic       CPOL      = 1'b1,
  parameter logic       CPHA      = 1'b1,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_cs,
  input  logic       i_sclk,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_start,
  output logic       o_frame_end,
  output logic       o_tx_underrun,
  output logic       o_rx_partial
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_cs_s1, r_cs_s2, r_cs_s3;
  logic       r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic       r_mosi_s1, r_mosi_s2;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic [7:0] r_miso_shift;
  logic [7:0] r_tx_buf;

  logic       w_sclk_edge, w_lead, w_trail, w_sample, w_shift;
  logic       w_cs_fall, w_cs_rise;
  logic       w_start, w_end, w_run, w_byte_done, w_fetch;
  logic [7:0] w_fetch_byte;

  assign w_sclk_edge  = r_sclk_s2 != r_sclk_s3;
  assign w_lead       = w_sclk_edge && (r_sclk_s2 != CPOL);
  assign w_trail      = w_sclk_edge && (r_sclk_s2 == CPOL);
  assign w_sample     = CPHA ? w_trail : w_lead;
  assign w_shift      = CPHA ? w_lead : w_trail;
  assign w_cs_fall    = r_cs_s3 && !r_cs_s2;
  assign w_cs_rise    = !r_cs_s3 && r_cs_s2;
  assign w_fetch_byte = i_tx_valid ? i_tx_data : FILL_BYTE;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_cs_fall) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_cs_rise) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // A cs rise outranks any sclk edge seen in the same cycle.
  always_comb begin
    o_miso_oe   = 1'b0;
    o_miso      = 1'b1;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_run       = 1'b0;
    if (r_state == ST_ACTIVE) begin
      o_miso_oe = 1'b1;
      o_miso    = r_miso_shift[7];
      w_end     = w_cs_rise;
      w_run     = !w_cs_rise;
    end else begin
      w_start   = w_cs_fall;
    end
    w_byte_done   = w_run && w_sample && (r_bit_cnt == 3'd7);
    w_fetch       = !i_sys_rst && (w_start || w_byte_done);
    o_tx_ready    = w_fetch && i_tx_valid;
    o_tx_underrun = w_fetch && !i_tx_valid;
    o_frame_start = !i_sys_rst && w_start;
    o_frame_end   = !i_sys_rst && w_end;
    o_rx_partial  = !i_sys_rst && w_end && (r_bit_cnt != 3'd0);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_cs_s1      <= 1'b1;
      r_cs_s2      <= 1'b1;
      r_cs_s3      <= 1'b1;
      r_sclk_s1    <= CPOL;
      r_sclk_s2    <= CPOL;
      r_sclk_s3    <= CPOL;
      r_mosi_s1    <= 1'b0;
      r_mosi_s2    <= 1'b0;
      r_bit_cnt    <= 3'd0;
      r_rx_shift   <= 8'h00;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_miso_shift <= 8'hFF;
      r_tx_buf     <= FILL_BYTE;
    end else begin
      r_cs_s1    <= i_cs;
      r_cs_s2    <= r_cs_s1;
      r_cs_s3    <= r_cs_s2;
      r_sclk_s1  <= i_sclk;
      r_sclk_s2  <= r_sclk_s1;
      r_sclk_s3  <= r_sclk_s2;
      r_mosi_s1  <= i_mosi;
      r_mosi_s2  <= r_mosi_s1;
      r_rx_valid <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= 3'd0;
        // CPHA=0 must present bit7 before the first edge; CPHA=1 loads it on that edge.
        if (CPHA) r_tx_buf <= w_fetch_byte;
        else      r_miso_shift <= w_fetch_byte;
      end
      if (w_run && w_sample) begin
        r_rx_shift <= {r_rx_shift[6:0], r_mosi_s2};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data  <= {r_rx_shift[6:0], r_mosi_s2};
          r_rx_valid <= 1'b1;
          r_tx_buf   <= w_fetch_byte;
        end
      end
      if (w_run && w_shift) begin
        if (r_bit_cnt == 3'd0) r_miso_shift <= r_tx_buf;
        else                   r_miso_shift <= {r_miso_shift[6:0], 1'b1};
      end
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_target_byte.sv
// Bench for spi_target_byte: a CPHA=0 and a CPHA=1 instance (both CPOL=1) driven by a
// behavioural SPI master at sys_clk/10, checked against byte-level expectations.
module tb_spi_target_byte;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] cs = 2'b11, sclk = 2'b11, mosi = 2'b00;
  logic [1:0] miso, miso_oe, tx_ready, rx_valid, frame_start, frame_end, tx_underrun, rx_partial;
  logic [1:0] tx_valid = 2'b00;
  logic [7:0] tx_data [2] = '{8'h00, 8'h00};
  logic [7:0] rx_data [2];

  int checks = 0;
  int errors = 0;
  int cur = 1;
  logic [7:0] mosi_q[$], txq[$], got_rx[$], got_miso[$];
  int cnt_ready, cnt_under, cnt_fs, cnt_fe, cnt_part, cnt_part_fe, cnt_rxv;
  logic first_miso, first_oe;

  always #5 sys_clk = ~sys_clk;

  spi_target_byte #(.CPOL(1'b1), .CPHA(1'b0), .FILL_BYTE(8'hFF)) u_dut_cpha0 (
    .i_sys_clk(sys_clk), .i_sys_rst(sys_rst), .i_cs(cs[0]), .i_sclk(sclk[0]), .i_mosi(mosi[0]),
    .o_miso(miso[0]), .o_miso_oe(miso_oe[0]), .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]),
    .o_tx_ready(tx_ready[0]), .o_rx_data(rx_data[0]), .o_rx_valid(rx_valid[0]),
    .o_frame_start(frame_start[0]), .o_frame_end(frame_end[0]),
    .o_tx_underrun(tx_underrun[0]), .o_rx_partial(rx_partial[0]));

  spi_target_byte #(.CPOL(1'b1), .CPHA(1'b1), .FILL_BYTE(8'hFF)) u_dut_cpha1 (
    .i_sys_clk(sys_clk), .i_sys_rst(sys_rst), .i_cs(cs[1]), .i_sclk(sclk[1]), .i_mosi(mosi[1]),
    .o_miso(miso[1]), .o_miso_oe(miso_oe[1]), .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]),
    .o_tx_ready(tx_ready[1]), .o_rx_data(rx_data[1]), .o_rx_valid(rx_valid[1]),
    .o_frame_start(frame_start[1]), .o_frame_end(frame_end[1]),
    .o_tx_underrun(tx_underrun[1]), .o_rx_partial(rx_partial[1]));

  // Fabric tx source: offers the head of txq to the instance under test.
  always @(posedge sys_clk) begin
    #1;
    for (int m = 0; m < 2; m++) begin
      tx_valid[m] = (m == cur) && (txq.size() > 0);
      tx_data[m]  = (m == cur && txq.size() > 0) ? txq[0] : 8'h00;
    end
  end

  // Fabric-side observer; a ready seen here is consumed at the next rising edge.
  always @(negedge sys_clk) begin
    if (tx_ready[cur]) begin
      cnt_ready++;
      if (txq.size() > 0) void'(txq.pop_front());
    end
    if (tx_underrun[cur]) cnt_under++;
    if (rx_valid[cur]) begin
      cnt_rxv++;
      got_rx.push_back(rx_data[cur]);
    end
    if (frame_start[cur]) cnt_fs++;
    if (frame_end[cur]) cnt_fe++;
    if (rx_partial[cur]) cnt_part++;
    if (rx_partial[cur] && frame_end[cur]) cnt_part_fe++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon(input int m);
    cur = m;
    txq.delete();
    mosi_q.delete();
    got_rx.delete();
    got_miso.delete();
    cnt_ready = 0; cnt_under = 0; cnt_fs = 0; cnt_fe = 0;
    cnt_part = 0; cnt_part_fe = 0; cnt_rxv = 0;
    repeat (2) @(negedge sys_clk);
  endtask

  // Behavioural SPI master (CPOL=1): sends nbits of mosi_q MSB first, assembles MISO bytes.
  task automatic spi_frame(input int m, input int nbits);
    logic [7:0] rb, bt;
    int j;
    rb = 8'h00;
    bt = (mosi_q.size() > 0) ? mosi_q[0] : 8'h00;
    if (m == 0) mosi[m] = bt[7];
    cs[m] = 1'b0;
    repeat (10) @(negedge sys_clk);
    first_miso = miso[m];
    first_oe   = miso_oe[m];
    for (int i = 0; i < nbits; i++) begin
      bt = (i / 8 < int'(mosi_q.size())) ? mosi_q[i / 8] : 8'h00;
      if (m == 1) begin
        sclk[m] = 1'b0;
        mosi[m] = bt[7 - (i % 8)];
        repeat (5) @(negedge sys_clk);
        rb = {rb[6:0], miso[m]};
        sclk[m] = 1'b1;
        repeat (5) @(negedge sys_clk);
      end else begin
        rb = {rb[6:0], miso[m]};
        sclk[m] = 1'b0;
        repeat (5) @(negedge sys_clk);
        sclk[m] = 1'b1;
        j  = i + 1;
        bt = (j / 8 < int'(mosi_q.size())) ? mosi_q[j / 8] : 8'h00;
        mosi[m] = bt[7 - (j % 8)];
        repeat (5) @(negedge sys_clk);
      end
      if (i % 8 == 7) got_miso.push_back(rb);
    end
    repeat (5) @(negedge sys_clk);
    cs[m] = 1'b1;
    repeat (15) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({miso[m], miso_oe[m]} !== 2'b10) begin
        errors++;
        $display("FAIL reset_pins[%0d]: miso/oe=%b%b expected 10", m, miso[m], miso_oe[m]);
      end
      checks++;
      if (rx_data[m] !== 8'h00) begin
        errors++;
        $display("FAIL reset_rx_data[%0d]: got %h expected 00", m, rx_data[m]);
      end
      checks++;
      if ({rx_valid[m], frame_start[m], frame_end[m], tx_ready[m], tx_underrun[m], rx_partial[m]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_pulses[%0d]: some pulse high, expected all 0", m);
      end
    end
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] v;
    clear_mon(1);
    mosi_q.push_back(8'hA5);
    txq.push_back(8'h3C); txq.push_back(8'h3C);
    spi_frame(1, 8);
    v = (got_rx.size() > 0) ? got_rx[0] : 8'hxx;
    checks++;
    if (cnt_rxv !== 1 || v !== 8'hA5 || rx_data[1] !== 8'hA5) begin
      errors++;
      $display("FAIL single_rx: pulses %0d byte %h rx_data %h expected 1 A5 A5", cnt_rxv, v, rx_data[1]);
    end
    v = (got_miso.size() > 0) ? got_miso[0] : 8'hxx;
    checks++;
    if (v !== 8'h3C) begin
      errors++;
      $display("FAIL single_miso: master got %h expected 3C", v);
    end
    checks++;
    if (cnt_ready !== 2 || cnt_under !== 0) begin
      errors++;
      $display("FAIL single_fetch: ready %0d underrun %0d expected 2 0", cnt_ready, cnt_under);
    end
    checks++;
    if (cnt_fs !== 1 || cnt_fe !== 1) begin
      errors++;
      $display("FAIL single_frame: start %0d end %0d expected 1 1", cnt_fs, cnt_fe);
    end
  endtask

  task automatic test_two_byte();
    logic [7:0] v0, v1, m0, m1;
    clear_mon(1);
    mosi_q.push_back(8'h12); mosi_q.push_back(8'h34);
    txq.push_back(8'hC3); txq.push_back(8'h5A);
    spi_frame(1, 16);
    v0 = (got_rx.size() > 0) ? got_rx[0] : 8'hxx;
    v1 = (got_rx.size() > 1) ? got_rx[1] : 8'hxx;
    m0 = (got_miso.size() > 0) ? got_miso[0] : 8'hxx;
    m1 = (got_miso.size() > 1) ? got_miso[1] : 8'hxx;
    checks++;
    if (got_rx.size() != 2 || v0 !== 8'h12 || v1 !== 8'h34) begin
      errors++;
      $display("FAIL two_rx: n=%0d %h %h expected 2 12 34", got_rx.size(), v0, v1);
    end
    checks++;
    if (m0 !== 8'hC3 || m1 !== 8'h5A) begin
      errors++;
      $display("FAIL two_miso: %h %h expected C3 5A", m0, m1);
    end
    checks++;
    if (cnt_fe !== 1 || cnt_part !== 0) begin
      errors++;
      $display("FAIL two_end: frame_end %0d partial %0d expected 1 0", cnt_fe, cnt_part);
    end
    // Third fetch at the end of byte 1 finds the queue empty.
    checks++;
    if (cnt_ready !== 2 || cnt_under !== 1) begin
      errors++;
      $display("FAIL two_fetch: ready %0d underrun %0d expected 2 1", cnt_ready, cnt_under);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] m0, m1;
    clear_mon(1);
    mosi_q.push_back(8'($urandom_range(0, 255)));
    mosi_q.push_back(8'($urandom_range(0, 255)));
    spi_frame(1, 16);
    m0 = (got_miso.size() > 0) ? got_miso[0] : 8'hxx;
    m1 = (got_miso.size() > 1) ? got_miso[1] : 8'hxx;
    checks++;
    if (m0 !== 8'hFF || m1 !== 8'hFF) begin
      errors++;
      $display("FAIL underrun_miso: %h %h expected FF FF", m0, m1);
    end
    // Two underruns feed the sent bytes; the byte-end fetch after byte 1 adds a third, discarded at cs rise.
    checks++;
    if (cnt_ready !== 0 || cnt_under !== 3) begin
      errors++;
      $display("FAIL underrun_count: ready %0d underrun %0d expected 0 3", cnt_ready, cnt_under);
    end
  endtask

  task automatic test_cpha0();
    logic [7:0] v, mb;
    clear_mon(0);
    mosi_q.push_back(8'h7E);
    txq.push_back(8'h81);
    spi_frame(0, 8);
    checks++;
    if (first_oe !== 1'b1 || first_miso !== 1'b1) begin
      errors++;
      $display("FAIL cpha0_first_bit: oe %b miso %b expected 1 1", first_oe, first_miso);
    end
    mb = (got_miso.size() > 0) ? got_miso[0] : 8'hxx;
    checks++;
    if (mb !== 8'h81) begin
      errors++;
      $display("FAIL cpha0_miso: %h expected 81", mb);
    end
    v = (got_rx.size() > 0) ? got_rx[0] : 8'hxx;
    checks++;
    if (v !== 8'h7E || rx_data[0] !== 8'h7E) begin
      errors++;
      $display("FAIL cpha0_rx: pulse byte %h rx_data %h expected 7E", v, rx_data[0]);
    end
  endtask

  task automatic test_partial();
    logic [7:0] prev;
    clear_mon(1);
    prev = rx_data[1];
    mosi_q.push_back(8'($urandom_range(0, 255)));
    txq.push_back(8'h99);
    spi_frame(1, 5);
    checks++;
    if (cnt_part_fe !== 1 || cnt_fe !== 1) begin
      errors++;
      $display("FAIL partial_flag: partial_with_end %0d frame_end %0d expected 1 1", cnt_part_fe, cnt_fe);
    end
    checks++;
    if (cnt_rxv !== 0 || rx_data[1] !== prev) begin
      errors++;
      $display("FAIL partial_rx: rx_valid %0d rx_data %h expected 0 %h", cnt_rxv, rx_data[1], prev);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v;
    clear_mon(1);
    cs[1] = 1'b0;
    repeat (10) @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      sclk[1] = 1'b0; mosi[1] = 1'b1;
      repeat (5) @(negedge sys_clk);
      sclk[1] = 1'b1;
      repeat (5) @(negedge sys_clk);
    end
    sys_rst = 1'b1;
    cs[1] = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (miso_oe[1] !== 1'b0 || miso[1] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pins: oe %b miso %b expected 0 1", miso_oe[1], miso[1]);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    cnt_fe = 0; cnt_rxv = 0; cnt_fs = 0; cnt_part = 0;
    repeat (20) @(negedge sys_clk);
    checks++;
    if (cnt_fe !== 0 || cnt_rxv !== 0 || cnt_fs !== 0 || cnt_part !== 0) begin
      errors++;
      $display("FAIL midrst_pulses: fe %0d rxv %0d fs %0d part %0d expected all 0", cnt_fe, cnt_rxv, cnt_fs, cnt_part);
    end
    clear_mon(1);
    mosi_q.push_back(8'h55);
    spi_frame(1, 8);
    v = (got_rx.size() > 0) ? got_rx[0] : 8'hxx;
    checks++;
    if (v !== 8'h55 || rx_data[1] !== 8'h55) begin
      errors++;
      $display("FAIL midrst_frame: pulse byte %h rx_data %h expected 55", v, rx_data[1]);
    end
  endtask

  // Random frames: byte-level model of what both sides should see.
  task automatic test_random();
    logic [7:0] snap[$];
    logic [7:0] exp_b, got_b;
    int m, nfull, extra, qlen, nfetch, exp_ready;
    for (int it = 0; it < 10; it++) begin
      m = $urandom_range(0, 1);
      nfull = $urandom_range(1, 3);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      qlen = $urandom_range(0, 4);
      clear_mon(m);
      for (int k = 0; k < nfull + 1; k++) mosi_q.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < qlen; k++) txq.push_back(8'($urandom_range(0, 255)));
      snap = txq;
      spi_frame(m, nfull * 8 + extra);
      nfetch = nfull + 1;
      exp_ready = (qlen < nfetch) ? qlen : nfetch;
      checks++;
      if (cnt_ready !== exp_ready || cnt_under !== nfetch - exp_ready) begin
        errors++;
        $display("FAIL rand%0d_fetch: ready %0d underrun %0d expected %0d %0d", it, cnt_ready, cnt_under, exp_ready, nfetch - exp_ready);
      end
      checks++;
      if (got_rx.size() != nfull || cnt_fs !== 1 || cnt_fe !== 1 || cnt_part !== int'(extra != 0)) begin
        errors++;
        $display("FAIL rand%0d_frame: rx %0d fs %0d fe %0d part %0d expected %0d 1 1 %0d", it, got_rx.size(), cnt_fs, cnt_fe, cnt_part, nfull, int'(extra != 0));
      end
      for (int k = 0; k < nfull; k++) begin
        exp_b = mosi_q[k];
        got_b = (k < int'(got_rx.size())) ? got_rx[k] : 8'hxx;
        checks++;
        if (got_b !== exp_b) begin
          errors++;
          $display("FAIL rand%0d_rx%0d: got %h expected %h", it, k, got_b, exp_b);
        end
        exp_b = (k < qlen) ? snap[k] : 8'hFF;
        got_b = (k < int'(got_miso.size())) ? got_miso[k] : 8'hxx;
        checks++;
        if (got_b !== exp_b) begin
          errors++;
          $display("FAIL rand%0d_miso%0d: got %h expected %h", it, k, got_b, exp_b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_byte();
    test_underrun();
    test_cpha0();
    test_partial();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
